// File: rtl/data_mem_sized.sv
// Purpose : RISC-V data memory with sized sign/zero-extended loads, byte/half/word
//           stores, a valid/ready request port and a post-reset clear sweep.
// Latency : response strobe LATENCY+1 cycles after acceptance; backpressure via req_ready=0 in CLEAR/WAIT/RESP.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake (accepted when both high at a rising edge)
//   req_we, req_funct3       store/load select and RISC-V access size/sign
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle response strobe
//   resp_rdata, resp_err     extended load data / fault flag, held until the next response
//   init_done                clear sweep finished (sticky until reset)
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses fault (no write, resp_rdata=0)
//   undefined : low address bits are forced to natural alignment, no fault

module data_mem_sized #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [3:0]      lat_cnt;
    logic [31:0]     pend_rdata;
    logic            pend_err;

    logic [31:0]     mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Request decode (combinational, evaluated at the acceptance edge)
    // ------------------------------------------------------------------
    logic            accept;
    logic [AW-1:0]   widx;
    logic            in_range;
    logic            size_ok;
    logic [1:0]      boff;
    logic            acc_err;
    logic            do_write;
    logic [31:0]     rd_word;
    logic [31:0]     rd_shift;
    logic [31:0]     ld_ext;
    logic [31:0]     ld_data;
    logic [31:0]     st_data;
    logic [3:0]      st_be;

    assign accept   = req_valid && req_ready;
    assign widx     = req_addr[AW+1:2];
    // Any set bit above the implemented index range is an out-of-range access.
    assign in_range = (req_addr[31:AW+2] == '0);

    // Size legality and the byte offset actually used. Half and word offsets
    // are forced to natural alignment here; in trap mode a misaligned access
    // faults anyway, so the forced offset never reaches memory.
    always_comb begin
        size_ok = 1'b0;
        boff    = 2'b00;
        case (req_funct3)
            3'b000: begin size_ok = 1'b1;     boff = req_addr[1:0];        end
            3'b001: begin size_ok = 1'b1;     boff = {req_addr[1], 1'b0};  end
            3'b010: begin size_ok = 1'b1;     boff = 2'b00;                end
            3'b100: begin size_ok = !req_we;  boff = req_addr[1:0];        end
            3'b101: begin size_ok = !req_we;  boff = {req_addr[1], 1'b0};  end
            default: begin size_ok = 1'b0;    boff = 2'b00;                end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misal;
    always_comb begin
        misal = 1'b0;
        if ((req_funct3 == 3'b001) || (req_funct3 == 3'b101))
            misal = req_addr[0];
        else if (req_funct3 == 3'b010)
            misal = (req_addr[1:0] != 2'b00);
    end
    assign acc_err = !size_ok || !in_range || misal;
`else
    assign acc_err = !size_ok || !in_range;
`endif

    // Load path: read the word, bring the addressed lane to bit 0, extend.
    assign rd_word  = mem[widx];
    assign rd_shift = rd_word >> {boff, 3'b000};

    always_comb begin
        ld_ext = '0;
        case (req_funct3)
            3'b000:  ld_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_ext = rd_shift;
            3'b100:  ld_ext = {24'h000000, rd_shift[7:0]};
            3'b101:  ld_ext = {16'h0000,   rd_shift[15:0]};
            default: ld_ext = '0;
        endcase
    end

    // Stores and faulted accesses report zero data.
    assign ld_data = (req_we || acc_err) ? 32'h0 : ld_ext;

    // Store path: replicate the low lane(s) across the word and enable only
    // the addressed bytes.
    always_comb begin
        st_data = req_wdata;
        st_be   = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_be   = 4'b0001 << boff;
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_be   = 4'b0011 << boff;
            end
            2'b10: begin
                st_data = req_wdata;
                st_be   = 4'b1111;
            end
            default: begin
                st_data = req_wdata;
                st_be   = 4'b0000;
            end
        endcase
    end

    assign do_write = accept && req_we && !acc_err;

    // ------------------------------------------------------------------
    // Storage. Not reset: a store accepted just before reset survives until
    // the clear sweep reaches its word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b])
                    mem[widx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            lat_cnt    <= '0;
            pend_rdata <= '0;
            pend_err   <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                        clr_cnt   <= '0;
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= ld_data;
                            resp_err   <= acc_err;
                        end else begin
                            // Result is captured now; later stores cannot
                            // reach this word before the response anyway.
                            state      <= S_WAIT;
                            lat_cnt    <= 4'(LATENCY);
                            pend_rdata <= ld_data;
                            pend_err   <= acc_err;
                        end
                    end
                end

                S_WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        lat_cnt    <= '0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= pend_rdata;
                        resp_err   <= pend_err;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end

                default: begin
                    state     <= S_CLEAR;
                    clr_cnt   <= '0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Purpose : directed self-checking bench for data_mem_sized (two instances:
//           DEPTH_WORDS=16/LATENCY=0 and DEPTH_WORDS=256/LATENCY=3).
// Timing  : inputs driven and outputs sampled 1 time unit after the rising edge.

module tb_data_mem_sized;

    logic clk;
    logic rst_n;

    // Instance 0: 16 words, no extra latency
    logic        v0, rdy0, we0, rv0, er0, id0;
    logic [2:0]  f30;
    logic [31:0] a0, wd0, rd0;

    // Instance 3: 256 words, LATENCY=3
    logic        v3, rdy3, we3, rv3, er3, id3;
    logic [2:0]  f33;
    logic [31:0] a3, wd3, rd3;

    int errors;
    int checks;

    data_mem_sized #(.DEPTH_WORDS(16), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_funct3(f30),
        .req_addr(a0), .req_wdata(wd0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .init_done(id0)
    );

    data_mem_sized #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_funct3(f33),
        .req_addr(a3), .req_wdata(wd3),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3), .init_done(id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the selected instance and wait for its response.
    // lat = cycles from acceptance to the cycle with resp_valid high.
    task automatic do_req(input int sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!((sel == 0) ? rdy0 : rdy3) && n < 400) begin
            tick();
            n++;
        end
        if (!((sel == 0) ? rdy0 : rdy3)) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout inst=%0d: ready=0, required 1", sel);
        end
        if (sel == 0) begin
            v0 = 1'b1; we0 = we; f30 = f3; a0 = addr; wd0 = wdata;
        end else begin
            v3 = 1'b1; we3 = we; f33 = f3; a3 = addr; wd3 = wdata;
        end
        tick();
        v0 = 1'b0;
        v3 = 1'b0;
        lat = 1;
        while (!((sel == 0) ? rv0 : rv3) && lat < 40) begin
            tick();
            lat++;
        end
        if (!((sel == 0) ? rv0 : rv3)) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout inst=%0d: resp_valid=0, required 1", sel);
        end
        rdata = (sel == 0) ? rd0 : rd3;
        err   = (sel == 0) ? er0 : er3;
    endtask

    task automatic test_reset;
        int  k;
        logic early_ready;
        rst_n = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({rdy0, rv0, er0, id0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl_u0: got %b, required 0000", {rdy0, rv0, er0, id0});
        end
        checks++;
        if (rd0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata_u0: got %h, required 00000000", rd0);
        end
        checks++;
        if ({rdy3, rv3, er3, id3} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl_u3: got %b, required 0000", {rdy3, rv3, er3, id3});
        end
        checks++;
        if (rd3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata_u3: got %h, required 00000000", rd3);
        end

        rst_n = 1'b1;
        k = 0;
        early_ready = 1'b0;
        while (!id0 && k < 40) begin
            if (rdy0) early_ready = 1'b1;
            tick();
            k++;
        end
        checks++;
        if (k !== 16) begin
            errors++;
            $display("FAIL sweep_len_u0: init_done after %0d cycles, required 16", k);
        end
        checks++;
        if (early_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_sweep_u0: got 1, required 0");
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_sweep_u0: got %b, required 1", rdy0);
        end
        while (!id3 && k < 400) begin
            tick();
            k++;
        end
        checks++;
        if (k !== 256) begin
            errors++;
            $display("FAIL sweep_len_u3: init_done after %0d cycles, required 256", k);
        end
    endtask

    task automatic test_cleared_read;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b0, 3'b010, 32'h3C, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'h0) begin
            errors++;
            $display("FAIL lw_after_clear: err=%b data=%h, required err=0 data=00000000", er, rd);
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL latency0: got %0d, required 1", lat);
        end
    endtask

    task automatic test_sized_loads;
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [2:0]  f3s [5];
        logic [31:0] adr [5];
        logic [31:0] exp [5];
        f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        adr = '{32'h17, 32'h17, 32'h16, 32'h16, 32'h14};
        exp = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};

        do_req(0, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if ({er, rd} !== 33'h0) begin
            errors++;
            $display("FAIL sw_resp: err=%b data=%h, required err=0 data=00000000", er, rd);
        end
        for (int i = 0; i < 5; i++) begin
            do_req(0, 1'b0, f3s[i], adr[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_f3_%b_addr_%h: got %h err=%b, required %h err=0",
                         f3s[i], adr[i], rd, er, exp[i]);
            end
        end
    endtask

    task automatic test_sub_word_stores;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(0, 1'b1, 3'b010, 32'h20, 32'hCAFEBABE, rd, er, lat);
        do_req(0, 1'b1, 3'b000, 32'h21, 32'hAAAAAA11, rd, er, lat);
        do_req(0, 1'b1, 3'b001, 32'h22, 32'hBBBB2233, rd, er, lat);
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h223311BE || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_sh_merge: got %h err=%b, required 223311be err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        n = 0;
        while (!rdy0 && n < 10) begin tick(); n++; end
        v0 = 1'b1; we0 = 1'b0; f30 = 3'b010; a0 = 32'h14; wd0 = 32'h0;
        tick();
        // Second request held on the bus; must wait out the RESP cycle.
        f30 = 3'b100; a0 = 32'h14;
        checks++;
        if ({rv0, rdy0} !== 2'b10 || rd0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_first: valid/ready=%b data=%h, required 10 deadbeef", {rv0, rdy0}, rd0);
        end
        tick();
        checks++;
        if ({rv0, rdy0} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: valid/ready=%b, required 01", {rv0, rdy0});
        end
        tick();
        v0 = 1'b0;
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 32'h000000EF) begin
            errors++;
            $display("FAIL b2b_second: valid=%b data=%h, required 1 000000ef", rv0, rd0);
        end
    endtask

    task automatic test_latency;
        int          n;
        logic [31:0] rd;
        logic        er;
        int          lat;
        n = 0;
        while (!rdy3 && n < 10) begin tick(); n++; end
        v3 = 1'b1; we3 = 1'b0; f33 = 3'b010; a3 = 32'h3FC; wd3 = 32'h0;
        tick();
        v3 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (rv3 !== (c == 4)) begin
                errors++;
                $display("FAIL lat3_valid_c%0d: got %b, required %b", c, rv3, (c == 4));
            end
            checks++;
            if (rdy3 !== (c == 5)) begin
                errors++;
                $display("FAIL lat3_ready_c%0d: got %b, required %b", c, rdy3, (c == 5));
            end
            if (c == 4) begin
                checks++;
                if ({er3, rd3} !== 33'h0) begin
                    errors++;
                    $display("FAIL lw_last_word: err=%b data=%h, required err=0 data=00000000", er3, rd3);
                end
            end
            if (c == 2) begin
                // Pulse while busy: must be ignored, not queued.
                v3 = 1'b1; we3 = 1'b1; f33 = 3'b010; a3 = 32'h30; wd3 = 32'h12345678;
            end
            if (c == 3) v3 = 1'b0;
            tick();
        end
        do_req(3, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL ignored_pulse: word 0x30=%h, required 00000000", rd);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL latency3: got %0d, required 4", lat);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(3, 1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oob_0x400: err=%b data=%h, required err=1 data=00000000", er, rd);
        end
        do_req(0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL oob_0x40: err=%b data=%h, required err=1 data=00000000", er, rd);
        end
        do_req(0, 1'b0, 3'b011, 32'h14, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL funct3_011: err=%b data=%h, required err=1 data=00000000", er, rd);
        end
        do_req(0, 1'b1, 3'b100, 32'h14, 32'hFFFFFFFF, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL store_f3_100: err=%b, required 1", er);
        end
        do_req(0, 1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bad_store_nowrite: err=%b data=%h, required err=0 deadbeef", er, rd);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        exp_err;
        logic [31:0] exp_word;
        logic [31:0] exp_half;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err  = 1'b1;
        exp_word = 32'h223311BE;
        exp_half = 32'h0;
`else
        exp_err  = 1'b0;
        exp_word = 32'h55667788;
        exp_half = 32'h0000BEEF;
`endif
        do_req(0, 1'b1, 3'b010, 32'h22, 32'h55667788, rd, er, lat);
        checks++;
        if (er !== exp_err) begin
            errors++;
            $display("FAIL sw_misalign_err: got %b, required %b", er, exp_err);
        end
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if (rd !== exp_word) begin
            errors++;
            $display("FAIL sw_misalign_mem: got %h, required %h", rd, exp_word);
        end
        do_req(0, 1'b0, 3'b101, 32'h15, 32'h0, rd, er, lat);
        checks++;
        if (er !== exp_err || rd !== exp_half) begin
            errors++;
            $display("FAIL lhu_misalign: err=%b data=%h, required err=%b data=%h", er, rd, exp_err, exp_half);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          k;
        logic        pulsed;
        do_req(3, 1'b1, 3'b010, 32'h14, 32'hA5A5A5A5, rd, er, lat);
        k = 0;
        while (!rdy3 && k < 10) begin tick(); k++; end
        v3 = 1'b1; we3 = 1'b0; f33 = 3'b010; a3 = 32'h14; wd3 = 32'h0;
        tick();
        v3 = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy3, rv3, id3, id0} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, required 0000", {rdy3, rv3, id3, id0});
        end
        pulsed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rv3) pulsed = 1'b1;
        end
        rst_n = 1'b1;
        k = 0;
        while (!id3 && k < 400) begin
            if (rv3) pulsed = 1'b1;
            tick();
            k++;
        end
        checks++;
        if (k !== 256) begin
            errors++;
            $display("FAIL resweep_u3: init_done after %0d cycles, required 256", k);
        end
        checks++;
        if (pulsed !== 1'b0) begin
            errors++;
            $display("FAIL dropped_resp: resp_valid pulsed, required no pulse");
        end
        do_req(3, 1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL cleared_u3_0x14: got %h err=%b, required 00000000 err=0", rd, er);
        end
        do_req(0, 1'b0, 3'b010, 32'h14, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL cleared_u0_0x14: got %h err=%b, required 00000000 err=0", rd, er);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        v0 = 1'b0; we0 = 1'b0; f30 = 3'b000; a0 = 32'h0; wd0 = 32'h0;
        v3 = 1'b0; we3 = 1'b0; f33 = 3'b000; a3 = 32'h0; wd3 = 32'h0;

        test_reset();
        test_cleared_read();
        test_sized_loads();
        test_sub_word_stores();
        test_back_to_back();
        test_latency();
        test_errors();
        test_misalign();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
